// File: rtl/cell_config_sequencer_if.sv
// Handshake and decoder-side bus of the cell configuration sequencer.
// The checksum signal exists only when CFG_CHECKSUM_EN is defined.
interface cell_config_sequencer_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic                  dec_enable;
    logic [DATA_WIDTH-1:0] cfg_data;
    logic                  busy;
    logic                  done;
`ifdef CFG_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum;
`endif

    modport master (
        output start, abort, last_addr, in_valid, in_data,
        input  in_ready, addr_out, dec_enable, cfg_data, busy, done
`ifdef CFG_CHECKSUM_EN
        , input checksum
`endif
    );

    modport slave (
        input  start, abort, last_addr, in_valid, in_data,
        output in_ready, addr_out, dec_enable, cfg_data, busy, done
`ifdef CFG_CHECKSUM_EN
        , output checksum
`endif
    );
endinterface

// File: rtl/cell_config_sequencer.sv
// Walks cell addresses 0..last_addr, pairing each accepted config word with a
// one-cycle decoder strobe. Define CFG_CHECKSUM_EN for the XOR checksum output.
module cell_config_sequencer #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    cell_config_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] last_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  in_ready_q;
    logic                  dec_enable_q;
    logic                  busy_q;
    logic                  done_q;
`ifdef CFG_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q;
`endif

    // All outputs are registered; abort outranks every transition, including start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr_q       <= '0;
            last_q       <= '0;
            data_q       <= '0;
            in_ready_q   <= 1'b0;
            dec_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef CFG_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else if (bus.abort) begin
            state        <= IDLE;
            in_ready_q   <= 1'b0;
            dec_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        last_q     <= bus.last_addr;
                        addr_q     <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= LOAD;
`ifdef CFG_CHECKSUM_EN
                        checksum_q <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (bus.in_valid && in_ready_q) begin
                        data_q       <= bus.in_data;
                        in_ready_q   <= 1'b0;
                        dec_enable_q <= 1'b1;
                        state        <= WRITE;
`ifdef CFG_CHECKSUM_EN
                        checksum_q   <= checksum_q ^ bus.in_data;
`endif
                    end
                end
                WRITE: begin
                    dec_enable_q <= 1'b0;
                    // Compare before incrementing so an all-ones last address never wraps.
                    if (addr_q == last_q) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        addr_q     <= addr_q + ADDR_WIDTH'(1);
                        in_ready_q <= 1'b1;
                        state      <= LOAD;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    in_ready_q   <= 1'b0;
                    dec_enable_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.addr_out   = addr_q;
    assign bus.dec_enable = dec_enable_q;
    assign bus.cfg_data   = data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
`ifdef CFG_CHECKSUM_EN
    assign bus.checksum   = checksum_q;
`endif

endmodule

// File: doc/cell_config_sequencer.md
Name: cell_config_sequencer

Overview:
- Upstream feeder for the cell-select decoder.
- Accepts a stream of per-cell configuration words over a valid/ready handshake.
- Walks a binary cell address from 0 up to a programmable last address.
- For each accepted word, drives `addr_out` and a one-cycle `dec_enable` strobe, which connect to the decoder's `binary_in` and `enable`. `cfg_data` is held stable so the selected cell latches it.

Parameters:
- ADDR_WIDTH, 9, width of cell address; must equal the decoder IN_WIDTH.
- DATA_WIDTH, 8, width of one cell configuration word.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load sequence when idle.
- abort  input  1  level; returns the block to IDLE on the next edge.
- last_addr  input  ADDR_WIDTH  final cell address of the sequence; sampled on start.
- in_valid  input  1  upstream word valid.
- in_data  input  DATA_WIDTH  upstream configuration word.
- in_ready  output  1  block can accept a word this cycle.
- addr_out  output  ADDR_WIDTH  cell address to decoder binary_in.
- dec_enable  output  1  write strobe to decoder enable.
- cfg_data  output  DATA_WIDTH  configuration word broadcast to cells.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse at sequence completion.

Behaviour:
- Reset (rst_n=0, async): state=IDLE. All outputs 0: in_ready, addr_out, dec_enable, cfg_data, busy, done. Internal last-address register 0.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1: capture last_addr, set addr_out=0, go to LOAD.
  - start is ignored in all other states.
- LOAD:
  - in_ready=1, busy=1.
  - in_valid && in_ready: register in_data into cfg_data, go to WRITE.
  - Otherwise hold LOAD. No timeout.
- WRITE (exactly one cycle):
  - dec_enable=1, in_ready=0, busy=1. addr_out and cfg_data are stable for the whole cycle.
  - If addr_out == captured last address: go to DONE, addr_out holds.
  - Else: addr_out += 1, go to LOAD.
- DONE (one cycle):
  - done=1, busy=1, dec_enable=0.
  - Then go to IDLE. addr_out and cfg_data hold their last values.
- Throughput: one word per 2 cycles max (LOAD accept, WRITE strobe). last_addr=N gives exactly N+1 dec_enable strobes.
- Latency: word accepted at edge k gives dec_enable high in cycle k+1, with the matching addr_out/cfg_data.
- Address wrap: with last_addr = 2^ADDR_WIDTH-1 the sequence ends at all-ones. addr_out never wraps to 0 inside a sequence.
- last_addr=0: single word, single strobe at address 0, then done.
- abort:
  - Priority over every other transition in all states.
  - Next edge: state=IDLE; dec_enable, in_ready, busy cleared; done NOT asserted.
  - addr_out and cfg_data hold.
  - A word offered in the same cycle as abort is not accepted, because in_ready drops on that edge and that handshake is void.
- start and abort together in IDLE: abort wins, stay IDLE.
- Reset mid-sequence: immediate return to reset values. No strobe is emitted while rst_n=0.
- dec_enable is registered and glitch-free. It is never high outside WRITE.

Optional Feature:
- Macro: CFG_CHECKSUM_EN.
- Defined:
  - Extra output `checksum`, width DATA_WIDTH, reset 0.
  - Cleared to 0 on accepted start.
  - XOR-accumulates every accepted in_data word.
  - Holds its value through DONE and IDLE until the next start.
  - Not cleared by abort.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Basic load: last_addr=3, start, supply 0x11,0x22,0x33,0x44 with in_valid always 1 -> four dec_enable pulses, 2 cycles apart, at addr 0..3 with matching cfg_data; done pulse one cycle after the last strobe; busy low after.
- Backpressure: last_addr=2, in_valid toggles 1,0,0,1,... -> strobes only follow accepted words; addr_out never skips; exactly 3 strobes.
- Full range: ADDR_WIDTH=4, last_addr=15 -> 16 strobes at addr 0..15; no wrap to 0; done once.
- Abort: last_addr=7, abort asserted during the WRITE of addr 2 -> IDLE next edge, no done, dec_enable 0; a new start restarts at addr 0.
- Async reset: rst_n low mid-LOAD, asynchronously between clock edges -> all outputs 0 without waiting for a clock edge; start after release behaves as in the basic load case.
- Checksum (CFG_CHECKSUM_EN): words 0xA5,0x0F,0xF0 with last_addr=2 -> checksum=0x5A after done; a second start clears it to 0.
